// File: rtl/osd_trace_packetizer.sv
// osd_trace_packetizer
//   Captures trace events from NCH core-side trace ports into one holding
//   register per channel, moves them round-robin into a shared event FIFO and
//   serialises each event into a single DII event packet on the debug NoC.
//   Trace sources cannot stall: an event arriving at a full holding register
//   is dropped, counted per channel and in drop_count, and flagged in the next
//   packet sent for that channel.
//
// Optional feature: define OSD_TRACE_TIMESTAMP_EN to add a free-running 32-bit
//   timestamp that is captured with every event and sent as two extra flits.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   id, dest          own DII address (packet source) / DII destination
//   enable            capture enable (buffered events drain regardless)
//   trace_valid       per-channel event strobe
//   trace_id          per-channel 16-bit event id, channel i at [16i+15:16i]
//   trace_value       per-channel XLEN-bit value, channel i at [XLEN*i +: XLEN]
//   debug_out         flit output (valid, last, data)
//   debug_out_ready   flit accept
//   drop_count        total dropped events, saturating at 65535

package osd_trace_pkg;
   typedef struct packed {
      logic        valid;
      logic        last;
      logic [15:0] data;
   } dii_flit;
endpackage

module osd_trace_packetizer
   import osd_trace_pkg::*;
#(
   parameter int XLEN       = 64,
   parameter int NCH        = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [9:0]           id,
   input  logic [9:0]           dest,
   input  logic                 enable,
   input  logic [NCH-1:0]       trace_valid,
   input  logic [NCH*16-1:0]    trace_id,
   input  logic [NCH*XLEN-1:0]  trace_value,
   output dii_flit              debug_out,
   input  logic                 debug_out_ready,
   output logic [15:0]          drop_count
);

   localparam int NBEAT = XLEN / 16;
   localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int PW    = $clog2(FIFO_DEPTH);

`ifdef OSD_TRACE_TIMESTAMP_EN
   typedef enum logic [3:0] {
      S_IDLE, S_HDR_DEST, S_HDR_SRC, S_HDR_TYPE, S_EVT_ID, S_LOST,
      S_TS_LO, S_TS_HI, S_VALUE
   } state_t;
   localparam state_t S_AFTER_EVT = S_TS_LO;
`else
   typedef enum logic [3:0] {
      S_IDLE, S_HDR_DEST, S_HDR_SRC, S_HDR_TYPE, S_EVT_ID, S_LOST, S_VALUE
   } state_t;
   localparam state_t S_AFTER_EVT = S_VALUE;
`endif

   // holding registers and per-channel lost counters
   logic            hold_vld_q [NCH], hold_vld_d [NCH];
   logic [15:0]     hold_tid_q [NCH], hold_tid_d [NCH];
   logic [XLEN-1:0] hold_val_q [NCH], hold_val_d [NCH];
   logic            hold_lf_q  [NCH], hold_lf_d  [NCH];
   logic [7:0]      hold_lc_q  [NCH], hold_lc_d  [NCH];
   logic [7:0]      lost_cnt_q [NCH], lost_cnt_d [NCH];
`ifdef OSD_TRACE_TIMESTAMP_EN
   logic [31:0]     hold_ts_q  [NCH], hold_ts_d  [NCH];
   logic [31:0]     ts_q, ts_d;
   logic [31:0]     mem_ts [FIFO_DEPTH];
`endif

   // shared event FIFO; the serializer works on the head entry in place and
   // frees it only when the packet's last flit is accepted
   logic [3:0]      mem_ch  [FIFO_DEPTH];
   logic [15:0]     mem_tid [FIFO_DEPTH];
   logic [XLEN-1:0] mem_val [FIFO_DEPTH];
   logic            mem_lf  [FIFO_DEPTH];
   logic [7:0]      mem_lc  [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]     count_q, count_d;
   logic            fifo_full, fifo_pop;

   logic [CHW-1:0]  rr_q, rr_d;
   logic            grant_vld;
   int              grant_idx;
   int              ndrop;
   logic [16:0]     drop_sum;
   logic [15:0]     drop_count_q, drop_count_d;
   state_t          state_q, state_d;
   logic [3:0]      beat_q, beat_d;
   logic            accept;

   assign fifo_full  = (count_q == (PW+1)'(FIFO_DEPTH));
   assign drop_count = drop_count_q;

   // round-robin arbiter: search starts at rr_q, which points one past the
   // channel granted last
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = 0;
      for (int k = 0; k < NCH; k++) begin
         if (!grant_vld && !fifo_full && hold_vld_q[(int'(rr_q) + k) % NCH]) begin
            grant_vld = 1'b1;
            grant_idx = (int'(rr_q) + k) % NCH;
         end
      end
      rr_d = grant_vld ? CHW'((grant_idx + 1) % NCH) : rr_q;
   end

   // capture / drop; a register being moved this cycle is treated as empty
   always_comb begin
      hold_vld_d = hold_vld_q;
      hold_tid_d = hold_tid_q;
      hold_val_d = hold_val_q;
      hold_lf_d  = hold_lf_q;
      hold_lc_d  = hold_lc_q;
      lost_cnt_d = lost_cnt_q;
`ifdef OSD_TRACE_TIMESTAMP_EN
      hold_ts_d  = hold_ts_q;
      ts_d       = ts_q + 32'd1;
`endif
      ndrop = 0;
      if (grant_vld) hold_vld_d[grant_idx] = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         if (enable && trace_valid[c]) begin
            if (!hold_vld_d[c]) begin
               hold_vld_d[c] = 1'b1;
               hold_tid_d[c] = trace_id[16*c +: 16];
               hold_val_d[c] = trace_value[XLEN*c +: XLEN];
               hold_lf_d[c]  = (lost_cnt_q[c] != 8'd0);
               hold_lc_d[c]  = lost_cnt_q[c];
               lost_cnt_d[c] = 8'd0;
`ifdef OSD_TRACE_TIMESTAMP_EN
               hold_ts_d[c]  = ts_q;
`endif
            end else begin
               if (lost_cnt_q[c] != 8'hFF) lost_cnt_d[c] = lost_cnt_q[c] + 8'd1;
               ndrop = ndrop + 1;
            end
         end
      end
      drop_sum     = {1'b0, drop_count_q} + 17'(ndrop);
      drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end

   // serializer
   always_comb begin
      state_d         = state_q;
      beat_d          = beat_q;
      fifo_pop        = 1'b0;
      debug_out.valid = (state_q != S_IDLE);
      debug_out.last  = 1'b0;
      debug_out.data  = 16'h0000;
      accept          = debug_out.valid && debug_out_ready;
      case (state_q)
         S_IDLE: if (count_q != '0) state_d = S_HDR_DEST;
         S_HDR_DEST: begin
            debug_out.data = {6'b0, dest};
            if (accept) state_d = S_HDR_SRC;
         end
         S_HDR_SRC: begin
            debug_out.data = {6'b0, id};
            if (accept) state_d = S_HDR_TYPE;
         end
         S_HDR_TYPE: begin
            debug_out.data = {2'b10, 3'b000, mem_lf[rd_ptr_q], 2'b00, 4'b0000, mem_ch[rd_ptr_q]};
            if (accept) state_d = S_EVT_ID;
         end
         S_EVT_ID: begin
            debug_out.data = mem_tid[rd_ptr_q];
            if (accept) state_d = mem_lf[rd_ptr_q] ? S_LOST : S_AFTER_EVT;
         end
         S_LOST: begin
            debug_out.data = {8'h00, mem_lc[rd_ptr_q]};
            if (accept) state_d = S_AFTER_EVT;
         end
`ifdef OSD_TRACE_TIMESTAMP_EN
         S_TS_LO: begin
            debug_out.data = mem_ts[rd_ptr_q][15:0];
            if (accept) state_d = S_TS_HI;
         end
         S_TS_HI: begin
            debug_out.data = mem_ts[rd_ptr_q][31:16];
            if (accept) state_d = S_VALUE;
         end
`endif
         S_VALUE: begin
            debug_out.data = mem_val[rd_ptr_q][16*beat_q +: 16];
            debug_out.last = (beat_q == 4'(NBEAT - 1));
            if (accept) begin
               if (debug_out.last) begin
                  beat_d   = 4'd0;
                  fifo_pop = 1'b1;
                  // go straight to the next packet when another event waits
                  state_d  = (count_q > (PW+1)'(1)) ? S_HDR_DEST : S_IDLE;
               end else begin
                  beat_d = beat_q + 4'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      wr_ptr_d = wr_ptr_q + PW'(grant_vld);
      rd_ptr_d = rd_ptr_q + PW'(fifo_pop);
      count_d  = count_q + (PW+1)'(grant_vld) - (PW+1)'(fifo_pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < NCH; c++) begin
            hold_vld_q[c] <= 1'b0;
            hold_tid_q[c] <= '0;
            hold_val_q[c] <= '0;
            hold_lf_q[c]  <= 1'b0;
            hold_lc_q[c]  <= '0;
            lost_cnt_q[c] <= '0;
`ifdef OSD_TRACE_TIMESTAMP_EN
            hold_ts_q[c]  <= '0;
`endif
         end
`ifdef OSD_TRACE_TIMESTAMP_EN
         ts_q         <= '0;
`endif
         rr_q         <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         state_q      <= S_IDLE;
         beat_q       <= '0;
         drop_count_q <= '0;
      end else begin
         hold_vld_q   <= hold_vld_d;
         hold_tid_q   <= hold_tid_d;
         hold_val_q   <= hold_val_d;
         hold_lf_q    <= hold_lf_d;
         hold_lc_q    <= hold_lc_d;
         lost_cnt_q   <= lost_cnt_d;
`ifdef OSD_TRACE_TIMESTAMP_EN
         hold_ts_q    <= hold_ts_d;
         ts_q         <= ts_d;
`endif
         rr_q         <= rr_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         state_q      <= state_d;
         beat_q       <= beat_d;
         drop_count_q <= drop_count_d;
      end
   end

   // FIFO storage needs no reset; only the pointers define its contents
   always_ff @(posedge clk) begin
      if (grant_vld) begin
         mem_ch[wr_ptr_q]  <= 4'(grant_idx);
         mem_tid[wr_ptr_q] <= hold_tid_q[grant_idx];
         mem_val[wr_ptr_q] <= hold_val_q[grant_idx];
         mem_lf[wr_ptr_q]  <= hold_lf_q[grant_idx];
         mem_lc[wr_ptr_q]  <= hold_lc_q[grant_idx];
`ifdef OSD_TRACE_TIMESTAMP_EN
         mem_ts[wr_ptr_q]  <= hold_ts_q[grant_idx];
`endif
      end
   end

endmodule

// File: tb/tb_osd_trace_packetizer.sv
// Self-checking bench for osd_trace_packetizer: directed scenarios followed
// by a randomized phase, all compared each cycle against a queue-based
// packet-level reference model.
module tb_osd_trace_packetizer;
   import osd_trace_pkg::*;

   localparam int XLEN = 64;
   localparam int NCH  = 2;
   localparam int DEPTH = 4;
   localparam int NB   = XLEN / 16;
`ifdef OSD_TRACE_TIMESTAMP_EN
   localparam int TSF = 2;
`else
   localparam int TSF = 0;
`endif
   localparam logic [9:0] ID   = 10'h005;
   localparam logic [9:0] DEST = 10'h000;

   logic                clk = 1'b0;
   logic                rst;
   logic [9:0]          id_in, dest_in;
   logic                enable;
   logic [NCH-1:0]      trace_valid;
   logic [NCH*16-1:0]   trace_id;
   logic [NCH*XLEN-1:0] trace_value;
   dii_flit             dout;
   logic                ready;
   logic [15:0]         drop_count;

   int vectors = 0;
   int miscompares = 0;

   osd_trace_packetizer #(.XLEN(XLEN), .NCH(NCH), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .id(id_in), .dest(dest_in), .enable(enable),
      .trace_valid(trace_valid), .trace_id(trace_id), .trace_value(trace_value),
      .debug_out(dout), .debug_out_ready(ready), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct {
      int              ch;
      logic [15:0]     tid;
      logic [XLEN-1:0] val;
      bit              lf;
      logic [7:0]      lc;
      logic [31:0]     ts;
   } ev_t;

   ev_t  mfifo[$];
   ev_t  hr[NCH];
   bit   hv[NCH];
   int   lost[NCH];
   int   rr, idx, mdrop;
   bit   busy;
   logic [31:0] mts;

   logic [15:0] got[$];
   int          nlast;

   function automatic logic [15:0] pkt_flit(ev_t e, int i);
      logic [15:0] f[$];
      f.push_back({6'b0, DEST});
      f.push_back({6'b0, ID});
      f.push_back({2'b10, 3'b000, e.lf, 2'b00, 8'(e.ch)});
      f.push_back(e.tid);
      if (e.lf) f.push_back({8'h00, e.lc});
`ifdef OSD_TRACE_TIMESTAMP_EN
      f.push_back(e.ts[15:0]);
      f.push_back(e.ts[31:16]);
`endif
      for (int b = 0; b < NB; b++) f.push_back(e.val[16*b +: 16]);
      return f[i];
   endfunction

   function automatic int pkt_len(ev_t e);
      return 4 + (e.lf ? 1 : 0) + TSF + NB;
   endfunction

   task automatic model_step();
      int  n0, g;
      bit  pop;
      ev_t pe;
      if (rst) begin
         mfifo.delete();
         for (int c = 0; c < NCH; c++) begin hv[c] = 0; lost[c] = 0; end
         rr = 0; idx = 0; mdrop = 0; busy = 0; mts = 0;
         return;
      end
      n0  = mfifo.size();
      pop = 0;
      if (busy && ready) begin
         if (idx == pkt_len(mfifo[0]) - 1) pop = 1;
         else idx++;
      end
      g = -1;
      if (n0 < DEPTH)
         for (int k = 0; k < NCH; k++)
            if (g < 0 && hv[(rr + k) % NCH]) g = (rr + k) % NCH;
      if (g >= 0) begin
         pe = hr[g]; hv[g] = 0; rr = (g + 1) % NCH;
      end
      for (int c = 0; c < NCH; c++) begin
         if (enable && trace_valid[c]) begin
            if (!hv[c]) begin
               hr[c].ch = c; hr[c].tid = trace_id[16*c +: 16];
               hr[c].val = trace_value[XLEN*c +: XLEN];
               hr[c].lf = (lost[c] != 0); hr[c].lc = 8'(lost[c]);
               hr[c].ts = mts; lost[c] = 0; hv[c] = 1;
            end else begin
               if (lost[c] < 255) lost[c]++;
               if (mdrop < 65535) mdrop++;
            end
         end
      end
      if (pop) void'(mfifo.pop_front());
      if (g >= 0) mfifo.push_back(pe);
      if (pop) begin busy = (n0 > 1); idx = 0; end
      else if (!busy && n0 > 0) begin busy = 1; idx = 0; end
      mts = mts + 32'd1;
   endtask

   // ---------------- checking ----------------
   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      chk("valid", 32'(dout.valid), 32'(busy));
      if (busy) begin
         chk("data", 32'(dout.data), 32'(pkt_flit(mfifo[0], idx)));
         chk("last", 32'(dout.last), 32'(idx == pkt_len(mfifo[0]) - 1));
      end
      chk("drop_count", 32'(drop_count), 32'(mdrop));
   endtask

   // one clock: record the flit accepted at the coming edge, update the
   // model at the edge, compare on the falling edge
   task automatic tick();
      if (dout.valid === 1'b1 && ready === 1'b1) begin
         got.push_back(dout.data);
         if (dout.last) nlast++;
      end
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic ticks(int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic set_ev(int c, logic [15:0] tid, logic [XLEN-1:0] v);
      trace_valid[c] = 1'b1;
      trace_id[16*c +: 16] = tid;
      trace_value[XLEN*c +: XLEN] = v;
   endtask

   task automatic do_reset();
      rst = 1'b1; trace_valid = '0;
      ticks(2);
      rst = 1'b0;
      got.delete(); nlast = 0;
   endtask

   initial begin
      bit reached;
      logic [XLEN-1:0] v1;
      id_in = ID; dest_in = DEST; enable = 1'b1; ready = 1'b1;
      trace_valid = '0; trace_id = '0; trace_value = '0; rst = 1'b1;
      nlast = 0;
      // reset state
      do_reset();
      chk("reset_valid", 32'(dout.valid), 32'd0);
      chk("reset_drop", 32'(drop_count), 32'd0);

      // 1: single channel-0 event
      v1 = 64'h0011_2233_4455_6677;
      set_ev(0, 16'h1234, v1);
      tick();
      trace_valid = '0;
      ticks(16);
`ifndef OSD_TRACE_TIMESTAMP_EN
      begin
         logic [15:0] exp1 [8];
         exp1 = '{16'h0000, 16'h0005, 16'h8000, 16'h1234, 16'h6677, 16'h4455, 16'h2233, 16'h0011};
         chk("t1_len", 32'(got.size()), 32'd8);
         for (int i = 0; i < 8; i++) chk($sformatf("t1_flit%0d", i), 32'(got[i]), 32'(exp1[i]));
      end
`endif
      chk("t1_last", 32'(nlast), 32'd1);

      // 2: simultaneous channels, twice
      do_reset();
      for (int r = 0; r < 2; r++) begin
         set_ev(0, 16'(16'hA000 + r), {$urandom, $urandom});
         set_ev(1, 16'(16'hB000 + r), {$urandom, $urandom});
         tick();
         trace_valid = '0;
         ticks(24);
      end
      chk("t2_pkt0_type", 32'(got[2]), 32'h8000);
      chk("t2_pkt1_type", 32'(got[10 + TSF]), 32'h8001);
      chk("t2_pkts", 32'(nlast), 32'd4);
      chk("t2_drop", 32'(drop_count), 32'd0);

      // 4: enable=0 ignores inputs, buffered events still drain
      do_reset();
      ready = 1'b0;
      set_ev(0, 16'h0C00, {$urandom, $urandom});
      set_ev(1, 16'h0C01, {$urandom, $urandom});
      tick();
      enable = 1'b0; ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         trace_valid = NCH'($urandom);
         tick();
      end
      trace_valid = '0; enable = 1'b1;
      chk("t4_pkts", 32'(nlast), 32'd2);
      chk("t4_drop", 32'(drop_count), 32'd0);

      // 3: overrun while stalled
      do_reset();
      ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         set_ev(0, 16'(16'h3000 + i), {$urandom, $urandom});
         tick();
      end
      trace_valid = '0;
      ticks(3);
      chk("t3_drop", 32'(drop_count), 32'd3);
      ready = 1'b1;
      ticks(70);
      got.delete();
      set_ev(0, 16'h3F00, {$urandom, $urandom});
      tick();
      trace_valid = '0;
      ticks(20);
      chk("t3_type", 32'(got[2]), 32'h8400);
      chk("t3_lost", 32'(got[4]), 32'h0003);

      // 5: reset mid-packet
      do_reset();
      set_ev(0, 16'h5555, {$urandom, $urandom});
      tick();
      trace_valid = '0;
      reached = 0;
      for (int i = 0; i < 20 && !reached; i++) begin
         tick();
         if (got.size() >= 3) reached = 1;
      end
      chk("t5_reach3", 32'(reached), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_valid", 32'(dout.valid), 32'd0);
      chk("t5_drop", 32'(drop_count), 32'd0);
      got.delete(); nlast = 0;
      set_ev(1, 16'h5AAA, {$urandom, $urandom});
      tick();
      trace_valid = '0;
      ticks(16);
      chk("t5_len", 32'(got.size()), 32'(8 + TSF));
      chk("t5_last", 32'(nlast), 32'd1);

      // randomized phase
      for (int i = 0; i < 3000; i++) begin
         for (int c = 0; c < NCH; c++) begin
            trace_valid[c] = ($urandom_range(0, 3) == 0);
            trace_id[16*c +: 16] = 16'($urandom);
            trace_value[XLEN*c +: XLEN] = {$urandom, $urandom};
         end
         enable = ($urandom_range(0, 9) != 0);
         ready  = ($urandom_range(0, 3) != 0);
         rst    = ($urandom_range(0, 499) == 0);
         tick();
      end
      rst = 1'b0; trace_valid = '0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
